// File: rtl/pbox_iter_if.sv
// Job/result handshake bundle for the iterative bit-permutation engine.
// The master side offers jobs and consumes results; the slave side is the engine.
interface pbox_iter_if #(
  parameter int N  = 8,
  parameter int CW = 4
) ();
  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [CW-1:0]     in_count;
  logic [0:N*N-1]    in_state;
  logic              out_valid;
  logic              out_ready;
  logic [0:N*N-1]    out_res;
  logic              busy;

  modport master (
    output in_valid, in_mode, in_count, in_state, out_ready,
    input  in_ready, out_valid, out_res, busy
  );

  modport slave (
    input  in_valid, in_mode, in_count, in_state, out_ready,
    output in_ready, out_valid, out_res, busy
  );
endinterface

// File: rtl/pbox_iter.sv
// Iterative N x N bit-permutation engine. Each accepted job applies the
// forward (or inverse) P-layer permutation in_count times, one application
// per clock, then holds the result until the consumer takes it.
module pbox_iter #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  pbox_iter_if.slave bus
);

  localparam int W = N * N;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nx_s;
  logic [0:W-1]    s_r;
  logic [0:W-1]    s_nx_s;
  logic            m_r;
  logic            m_nx_s;
  logic [CW-1:0]   k_r;
  logic [CW-1:0]   k_nx_s;
  logic            in_ready_r;
  logic            out_valid_r;
  logic            busy_r;

  // Bit position inside each source byte that feeds output byte r:
  // odd bits for the first half of the rows, even bits for the second half.
  function automatic int bsel(input int r);
    int b;
    if (r < N / 2) begin
      b = 2 * r + 1;
    end else begin
      b = 2 * (r - N / 2);
    end
    return b;
  endfunction

  // Forward permutation: output byte r gathers bit bsel(r) of bytes N-1..0.
  function automatic logic [0:W-1] perm_fwd(input logic [0:W-1] v);
    logic [0:W-1] o;
    o = {W{1'b0}};
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        o[N*r+c] = v[N*(N-1-c)+bsel(r)];
      end
    end
    return o;
  endfunction

  // Inverse permutation: scatter each bit back to where the forward map took it.
  function automatic logic [0:W-1] perm_inv(input logic [0:W-1] v);
    logic [0:W-1] o;
    o = {W{1'b0}};
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        o[N*(N-1-c)+bsel(r)] = v[N*r+c];
      end
    end
    return o;
  endfunction

  // Next-state and datapath update for the IDLE -> RUN -> DONE job cycle.
  always_comb begin
    state_nx_s = state_r;
    s_nx_s     = s_r;
    m_nx_s     = m_r;
    k_nx_s     = k_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          state_nx_s = RUN;
          s_nx_s     = bus.in_state;
          m_nx_s     = bus.in_mode;
          k_nx_s     = bus.in_count;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (k_r == {CW{1'b0}}) begin
          state_nx_s = DONE;
        end else begin
          if (m_r) begin
            s_nx_s = perm_inv(s_r);
          end else begin
            s_nx_s = perm_fwd(s_r);
          end
          k_nx_s = k_r - CW'(1'b1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State, datapath and handshake flags; flags are decoded from the next
  // state so they come straight out of flops with no input-to-output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      s_r         <= {W{1'b0}};
      m_r         <= 1'b0;
      k_r         <= {CW{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      s_r         <= s_nx_s;
      m_r         <= m_nx_s;
      k_r         <= k_nx_s;
      in_ready_r  <= (state_nx_s == IDLE);
      out_valid_r <= (state_nx_s == DONE);
      busy_r      <= (state_nx_s == RUN) || (state_nx_s == DONE);
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.out_res   = s_r;

endmodule

// File: doc/pbox_iter.md
# pbox_iter

Iterative, parametrised bit-permutation engine for the HDLBC datapath. It generalises the fixed 64-bit P-layer to an N×N bit state. Each operation applies the forward or inverse permutation a programmable number of times, one application per clock. Jobs are accepted and results returned over valid/ready handshakes, so the block sits between the round-function register stage and the key-addition/output stage.

## Interface
Parameters:
- N, default 8: bytes per state and bits per byte; even, ≥2; state width is N*N.
- CW, default 4: width of the repeat-count field.

Ports:
- clk, input, 1: single clock; all state changes on rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- in_valid, input, 1: job offered.
- in_ready, output, 1: block can accept a job.
- in_mode, input, 1: 0 = forward permutation, 1 = inverse permutation.
- in_count, input, CW: number of permutation applications, 0..2^CW-1.
- in_state, input, [0:N*N-1]: input state, bit 0 = MSB.
- out_valid, output, 1: result available.
- out_ready, input, 1: downstream accepts the result.
- out_res, output, [0:N*N-1]: result state.
- busy, output, 1: high in RUN or DONE.

## Operation
- Bit indexing is MSB-first. Byte j occupies bits [N*j : N*j+N-1].
- b(r) = 2r+1 for r < N/2, and b(r) = 2(r−N/2) for r ≥ N/2.
- Forward permutation F: out[N*r+c] = in[N*(N−1−c)+b(r)] for r, c in 0..N−1.
  - For N=8 this is identical to the existing 64-bit P-layer: output byte 0 = bit 1 of bytes 7..0, …, output byte 7 = bit 6 of bytes 7..0.
- Inverse permutation F⁻¹: out[N*(N−1−c)+b(r)] = in[N*r+c].
- Internal registers: state register S (N*N bits), mode register M, down-counter K (CW bits), 2-bit FSM.
- FSM states:
  - IDLE: in_ready=1. If in_valid: S←in_state, M←in_mode, K←in_count, go to RUN.
  - RUN: if K==0, go to DONE with S unchanged. Otherwise S←(M ? F⁻¹(S) : F(S)) and K←K−1, staying in RUN.
  - DONE: out_valid=1 and out_res=S. If out_ready, go to IDLE; otherwise hold everything.
- in_ready is high only in IDLE. A new job never overlaps the result being held.
- out_res always drives S. It is valid only while out_valid=1.
- The count is a plain unsigned value with no saturation. in_count=0 returns in_state unmodified.
- in_mode and in_count are sampled only at acceptance. Later changes on these inputs are ignored.

## Timing
- Reset (asynchronous, any state): FSM=IDLE, S=0, M=0, K=0, in_ready=1, out_valid=0, busy=0, out_res=0.
- Reset mid-RUN or mid-DONE aborts the job. No output is produced for it.
- Accept edge E0: the edge where in_valid && in_ready in IDLE.
- out_valid rises exactly in_count+1 edges after E0.
  - in_count=0 gives 1-cycle latency.
  - in_count=15 gives 16-cycle latency.
- Handshake completes on the edge where out_valid && out_ready. in_ready rises the next cycle. Throughput is one job per in_count+3 cycles with no stalls.
- While out_ready=0 in DONE: out_res and out_valid stay stable indefinitely.
- in_valid while busy has no effect. The source must hold its job until in_ready.
- No combinational path from in_* to out_*.
- in_ready depends only on the FSM. It does not depend on out_ready.

## Test plan
- Reset and passthrough, N=8:
  - Check that after rst_n release, in_ready=1, out_valid=0, out_res=0.
  - Stimulus: in_state=64'h0123_4567_89AB_CDEF, count=0. Required: out_valid 1 cycle after accept with identical data.
- Single forward, N=8, count=1:
  - 64'h0000_0000_0000_0040 → 64'h8000_0000_0000_0000.
  - 64'h8000_0000_0000_0000 → 64'h0000_0000_0100_0000.
  - Both with out_valid 2 cycles after accept.
- Single inverse, count=1:
  - 64'h8000_0000_0000_0000 → 64'h0000_0000_0000_0040.
  - 64'h0000_0000_0100_0000 → 64'h8000_0000_0000_0000.
- Round trip:
  - Stimulus: random in_state, forward count=k, then the result with inverse count=k, for k in {1,5,15}. Required: original state returned.
  - Stimulus: all-ones and all-zero inputs, any count. Required: unchanged.
- Backpressure: hold out_ready=0 for 10 cycles in DONE, toggling in_valid/in_state meanwhile. Required:
  - out_res stable and in_ready=0 throughout.
  - The job is released exactly on the first out_ready=1 edge.
  - IDLE follows one cycle later.
- Reset mid-op: assert rst_n=0 asynchronously, mid-cycle, 3 cycles into a count=10 job. Required:
  - Outputs go to reset values immediately.
  - After release, a new count=1 job produces the correct result with no residue of the aborted job.
  - Repeat with N=4 (width 16) to cover parametrisation.
